mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master single-port memory arbiter with bounded bursts and tagged read returns
module mem_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int MAX_BURST  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_wr_en,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_gnt,
  output logic              m0_rd_valid,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_wr_en,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_gnt,
  output logic              m1_rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic                  last_owner;
  logic [CNT_W-1:0]      burst_cnt;
  logic [RD_LATENCY-1:0] pipe_valid;
  logic [RD_LATENCY-1:0] pipe_owner;

  logic turn_over;
  logic sel;
  logic any_gnt;

  // burst_cnt == 0 only right after reset: no live burst, so a contested
  // cycle goes to the master that is not last_owner (m0).
  assign turn_over = (burst_cnt == '0) || (burst_cnt >= CNT_W'(MAX_BURST));

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    sel    = last_owner;
    if (!reset) begin
      if (m0_req && m1_req) begin
        sel    = turn_over ? ~last_owner : last_owner;
        m0_gnt = ~sel;
        m1_gnt = sel;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign any_gnt = m0_gnt | m1_gnt;

  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    if (m0_gnt) begin
      mem_addr    = m0_addr;
      mem_wr_en   = m0_wr_en;
      mem_wr_data = m0_wr_data;
    end else if (m1_gnt) begin
      mem_addr    = m1_addr;
      mem_wr_en   = m1_wr_en;
      mem_wr_data = m1_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      pipe_valid <= '0;
      pipe_owner <= '0;
    end else begin
      if (any_gnt) begin
        if (m1_gnt == last_owner) begin
          if (burst_cnt < CNT_W'(MAX_BURST))
            burst_cnt <= burst_cnt + CNT_W'(1);
        end else begin
          last_owner <= m1_gnt;
          burst_cnt  <= CNT_W'(1);
        end
      end
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_owner[i] <= pipe_owner[i-1];
      end
      pipe_valid[0] <= any_gnt & ~mem_wr_en;
      pipe_owner[0] <= m1_gnt;
    end
  end

  // Gating with reset kills returns of reads issued before a reset.
  assign m0_rd_valid = ~reset & pipe_valid[RD_LATENCY-1] & ~pipe_owner[RD_LATENCY-1];
  assign m1_rd_valid = ~reset & pipe_valid[RD_LATENCY-1] &  pipe_owner[RD_LATENCY-1];
  assign rd_data     = (m0_rd_valid | m1_rd_valid) ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with directed and randomized traffic
module tb_mem_arbiter;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int MB = 4;
  localparam int RL = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          m0_req = 1'b0, m0_wr_en = 1'b0, m1_req = 1'b0, m1_wr_en = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wr_data = '0, m1_wr_data = '0;
  logic          m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid, mem_wr_en;
  logic [DW-1:0] rd_data, mem_wr_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB), .RD_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr_en(m0_wr_en), .m0_wr_data(m0_wr_data),
    .m0_gnt(m0_gnt), .m0_rd_valid(m0_rd_valid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr_en(m1_wr_en), .m1_wr_data(m1_wr_data),
    .m1_gnt(m1_gnt), .m1_rd_valid(m1_rd_valid),
    .rd_data(rd_data), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  // Memory: unwritten words read back as {8'hD0, addr[7:0]}, latency 1.
  bit [15:0] tb_mem [256];
  bit        tb_wr  [256];
  always @(posedge clk) begin
    mem_rd_data <= tb_wr[mem_addr[7:0]] ? tb_mem[mem_addr[7:0]] : {8'hD0, mem_addr[7:0]};
    if (mem_wr_en) begin
      tb_mem[mem_addr[7:0]] <= mem_wr_data;
      tb_wr[mem_addr[7:0]]  <= 1'b1;
    end
  end

  task set_m0(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    m0_req = r; m0_wr_en = w; m0_addr = a; m0_wr_data = d;
  endtask

  task set_m1(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    m1_req = r; m1_wr_en = w; m1_addr = a; m1_wr_data = d;
  endtask

  task do_reset;
    @(negedge clk);
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task test_reset;
    @(negedge clk);
    reset = 1'b1;
    set_m0(1, 1, 16'h1234, 16'h5678); set_m1(1, 1, 16'h4321, 16'h8765);
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++; if ({m0_gnt, m1_gnt} !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
      tests++; if (mem_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", mem_wr_en); end
      tests++; if (mem_addr !== 16'h0) begin fails++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
      tests++; if (mem_wr_data !== 16'h0) begin fails++; $display("FAIL reset_wdata: got %h want 0000", mem_wr_data); end
      tests++; if ({m0_rd_valid, m1_rd_valid} !== 2'b00 || rd_data !== 16'h0) begin
        fails++; $display("FAIL reset_rd: got v=%b d=%h want v=00 d=0000", {m0_rd_valid, m1_rd_valid}, rd_data); end
      @(negedge clk);
    end
    reset = 1'b0;
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
  endtask

  task test_contention;
    logic e0, ev0;
    do_reset;
    set_m0(1, 0, 16'h0010, 0); set_m1(1, 0, 16'h0020, 0);
    for (int c = 0; c < 16; c++) begin
      e0  = ((c / 4) % 2) == 0;
      ev0 = (c > 0) && (((c - 1) / 4) % 2 == 0);
      #1;
      tests++; if ({m0_gnt, m1_gnt} !== {e0, ~e0}) begin
        fails++; $display("FAIL contention_gnt c=%0d: got %b want %b", c, {m0_gnt, m1_gnt}, {e0, ~e0}); end
      tests++; if (mem_addr !== (e0 ? 16'h0010 : 16'h0020)) begin
        fails++; $display("FAIL contention_addr c=%0d: got %h want %h", c, mem_addr, e0 ? 16'h0010 : 16'h0020); end
      tests++; if (m0_rd_valid !== ev0 || m1_rd_valid !== (c > 0 && !ev0)) begin
        fails++; $display("FAIL contention_rdv c=%0d: got %b%b want %b%b", c, m0_rd_valid, m1_rd_valid, ev0, c > 0 && !ev0); end
      if (c > 0) begin
        tests++; if (rd_data !== (ev0 ? 16'hD010 : 16'hD020)) begin
          fails++; $display("FAIL contention_rdata c=%0d: got %h want %h", c, rd_data, ev0 ? 16'hD010 : 16'hD020); end
      end
      @(negedge clk);
    end
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
  endtask

  task test_write;
    do_reset;
    set_m1(1, 1, 16'hFFFD, 16'hBEEF);
    #1;
    tests++; if ({m0_gnt, m1_gnt} !== 2'b01) begin fails++; $display("FAIL write_gnt: got %b want 01", {m0_gnt, m1_gnt}); end
    tests++; if (mem_addr !== 16'hFFFD || mem_wr_en !== 1'b1 || mem_wr_data !== 16'hBEEF) begin
      fails++; $display("FAIL write_bus: got a=%h we=%b d=%h want a=fffd we=1 d=beef", mem_addr, mem_wr_en, mem_wr_data); end
    @(negedge clk);
    set_m1(0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++; if ({m0_rd_valid, m1_rd_valid} !== 2'b00 || rd_data !== 16'h0) begin
        fails++; $display("FAIL write_no_rdv c=%0d: got v=%b d=%h want v=00 d=0000", c, {m0_rd_valid, m1_rd_valid}, rd_data); end
      @(negedge clk);
    end
  endtask

  task test_saturation;
    do_reset;
    set_m0(1, 0, 16'h0030, 0);
    for (int c = 0; c < 10; c++) begin
      #1;
      tests++; if ({m0_gnt, m1_gnt} !== 2'b10) begin
        fails++; $display("FAIL solo_gnt c=%0d: got %b want 10", c, {m0_gnt, m1_gnt}); end
      @(negedge clk);
    end
    set_m1(1, 0, 16'h0040, 0);
    #1;
    tests++; if ({m0_gnt, m1_gnt} !== 2'b01) begin fails++; $display("FAIL saturated_switch: got %b want 01", {m0_gnt, m1_gnt}); end
    @(negedge clk);
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
  endtask

  task test_read_pipeline;
    logic [15:0] exp_d [3];
    logic [1:0]  exp_v [3];
    exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333;
    exp_v[0] = 2'b10;    exp_v[1] = 2'b01;    exp_v[2] = 2'b10;
    do_reset;
    for (int c = 0; c < 3; c++) begin
      set_m0(1, 1, 16'h0051 + 16'(c), exp_d[c]);
      @(negedge clk);
    end
    set_m0(1, 0, 16'h0051, 0);
    @(negedge clk);
    set_m0(0, 0, 0, 0); set_m1(1, 0, 16'h0052, 0);
    #1;
    tests++; if ({m0_rd_valid, m1_rd_valid} !== exp_v[0] || rd_data !== exp_d[0]) begin
      fails++; $display("FAIL pipe_ret0: got v=%b d=%h want v=%b d=%h", {m0_rd_valid, m1_rd_valid}, rd_data, exp_v[0], exp_d[0]); end
    @(negedge clk);
    set_m1(0, 0, 0, 0); set_m0(1, 0, 16'h0053, 0);
    #1;
    tests++; if ({m0_rd_valid, m1_rd_valid} !== exp_v[1] || rd_data !== exp_d[1]) begin
      fails++; $display("FAIL pipe_ret1: got v=%b d=%h want v=%b d=%h", {m0_rd_valid, m1_rd_valid}, rd_data, exp_v[1], exp_d[1]); end
    @(negedge clk);
    set_m0(0, 0, 0, 0);
    #1;
    tests++; if ({m0_rd_valid, m1_rd_valid} !== exp_v[2] || rd_data !== exp_d[2]) begin
      fails++; $display("FAIL pipe_ret2: got v=%b d=%h want v=%b d=%h", {m0_rd_valid, m1_rd_valid}, rd_data, exp_v[2], exp_d[2]); end
    @(negedge clk);
    #1;
    tests++; if ({m0_rd_valid, m1_rd_valid} !== 2'b00 || rd_data !== 16'h0) begin
      fails++; $display("FAIL pipe_drain: got v=%b d=%h want v=00 d=0000", {m0_rd_valid, m1_rd_valid}, rd_data); end
    @(negedge clk);
  endtask

  task test_reset_mid;
    do_reset;
    set_m1(1, 0, 16'h0060, 0);
    @(negedge clk);
    set_m1(0, 0, 0, 0); set_m0(1, 0, 16'h0061, 0);
    #1;
    tests++; if (m0_gnt !== 1'b1) begin fails++; $display("FAIL midreset_pre_gnt: got %b want 1", m0_gnt); end
    @(negedge clk);
    reset = 1'b1;
    set_m0(1, 0, 16'h0061, 0); set_m1(1, 0, 16'h0060, 0);
    #1;
    tests++; if ({m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid} !== 4'b0000 || rd_data !== 16'h0) begin
      fails++; $display("FAIL midreset_during: got g=%b v=%b d=%h want all 0", {m0_gnt, m1_gnt}, {m0_rd_valid, m1_rd_valid}, rd_data); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++; if ({m0_rd_valid, m1_rd_valid} !== 2'b00) begin
      fails++; $display("FAIL midreset_stale_rdv: got %b want 00", {m0_rd_valid, m1_rd_valid}); end
    tests++; if ({m0_gnt, m1_gnt} !== 2'b10) begin
      fails++; $display("FAIL midreset_first_contest: got %b want 10", {m0_gnt, m1_gnt}); end
    @(negedge clk);
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
  endtask

  task test_idle;
    logic [1:0] e;
    do_reset;
    set_m0(1, 0, 16'h0070, 0); set_m1(1, 0, 16'h0071, 0);
    for (int c = 0; c < 5; c++) begin
      e = (c < 4) ? 2'b10 : 2'b01;
      #1;
      tests++; if ({m0_gnt, m1_gnt} !== e) begin fails++; $display("FAIL idle_pre c=%0d: got %b want %b", c, {m0_gnt, m1_gnt}, e); end
      @(negedge clk);
    end
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++; if ({m0_gnt, m1_gnt, mem_wr_en} !== 3'b000 || mem_addr !== 16'h0 || mem_wr_data !== 16'h0) begin
        fails++; $display("FAIL idle_bus c=%0d: got g=%b we=%b a=%h d=%h want all 0", c, {m0_gnt, m1_gnt}, mem_wr_en, mem_addr, mem_wr_data); end
      @(negedge clk);
    end
    set_m0(1, 0, 16'h0070, 0); set_m1(1, 0, 16'h0071, 0);
    for (int c = 0; c < 4; c++) begin
      e = (c < 3) ? 2'b01 : 2'b10;
      #1;
      tests++; if ({m0_gnt, m1_gnt} !== e) begin fails++; $display("FAIL idle_resume c=%0d: got %b want %b", c, {m0_gnt, m1_gnt}, e); end
      @(negedge clk);
    end
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
  endtask

  typedef struct { int due; bit own; logic [15:0] data; } ret_t;
  bit [15:0] sh_mem [256];
  bit        sh_wr  [256];

  task test_random;
    ret_t        q[$];
    ret_t        r;
    bit          p0, p1;
    logic        w0, w1, ev0, ev1, gw;
    logic [15:0] a0, a1, d0, d1, ea, ed, ew, ga, gd;
    int          g, own, streak;
    p0 = 0; p1 = 0; own = 1; streak = 0;
    w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    do_reset;
    for (int k = 0; k < 400; k++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; a0 = 16'($urandom); a0[7:6] = 2'b10; w0 = 1'($urandom_range(0, 1)); d0 = 16'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; a1 = 16'($urandom); a1[7:6] = 2'b10; w1 = 1'($urandom_range(0, 1)); d1 = 16'($urandom);
      end
      set_m0(p0, w0, a0, d0); set_m1(p1, w1, a1, d1);
      if (p0 && p1) g = (streak == 0 || streak >= MB) ? 1 - own : own;
      else if (p0)  g = 0;
      else if (p1)  g = 1;
      else          g = -1;
      ea = (g == 0) ? a0 : (g == 1) ? a1 : 16'h0;
      ew = (g == 0) ? d0 : (g == 1) ? d1 : 16'h0;
      ev0 = 0; ev1 = 0; ed = 0;
      if (q.size() > 0 && q[0].due == k) begin
        r = q.pop_front();
        ev0 = !r.own; ev1 = r.own; ed = r.data;
      end
      #1;
      tests++; if (m0_gnt !== (g == 0) || m1_gnt !== (g == 1)) begin
        fails++; $display("FAIL rand_gnt k=%0d: got %b%b want %b%b", k, m0_gnt, m1_gnt, g == 0, g == 1); end
      tests++; if (mem_addr !== ea || mem_wr_data !== ew || mem_wr_en !== ((g == 0 && w0) || (g == 1 && w1))) begin
        fails++; $display("FAIL rand_bus k=%0d: got a=%h d=%h we=%b want a=%h d=%h", k, mem_addr, mem_wr_data, mem_wr_en, ea, ew); end
      tests++; if (m0_rd_valid !== ev0 || m1_rd_valid !== ev1 || rd_data !== ed) begin
        fails++; $display("FAIL rand_rd k=%0d: got v=%b%b d=%h want v=%b%b d=%h", k, m0_rd_valid, m1_rd_valid, rd_data, ev0, ev1, ed); end
      if (g >= 0) begin
        ga = g ? a1 : a0; gd = g ? d1 : d0; gw = g ? w1 : w0;
        if (gw) begin
          sh_mem[ga[7:0]] = gd; sh_wr[ga[7:0]] = 1;
        end else begin
          r.due = k + RL; r.own = (g == 1);
          r.data = sh_wr[ga[7:0]] ? sh_mem[ga[7:0]] : {8'hD0, ga[7:0]};
          q.push_back(r);
        end
        if (g == own) begin
          if (streak < MB) streak++;
        end else begin
          own = g; streak = 1;
        end
        if (g == 0) p0 = 0; else p1 = 0;
      end
      @(negedge clk);
    end
    set_m0(0, 0, 0, 0); set_m1(0, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_contention;
    test_write;
    test_saturation;
    test_read_pipeline;
    test_reset_mid;
    test_idle;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
